mux_arbitro_nx1: RTL and testbench

MUX_ARBITRO_NX1 -- requirements
Module: mux_arbitro_nx1

---
 rtl/mux_arbitro_nx1_pkg.sv | 19 +
 rtl/mux_arbitro_nx1_arbitro_rr.sv | 35 +++
 rtl/mux_arbitro_nx1.sv | 67 ++++++
 tb/tb_mux_arbitro_nx1.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_arbitro_nx1_pkg.sv
// Shared constants and the index-width helper for the N:1 arbitrated multiplexer.
package mux_arbitro_nx1_pkg;

    localparam int DEFAULT_WIDTH = 2;
    localparam int DEFAULT_N     = 4;

    // ceil(log2(n)), never less than 1 so a channel index always has a bit
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/mux_arbitro_nx1_arbitro_rr.sv
// Arbiter: grants the first requesting channel found searching from ptr upward,
// wrapping at N-1. Tie ptr to zero for plain lowest-index-first priority.
module arbitro_rr
    import mux_arbitro_nx1_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int IW = idx_width(DEFAULT_N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    always_comb begin
        int  cand;
        logic found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/mux_arbitro_nx1.sv
// N:1 arbitrated multiplexer with a one-word registered output stage.
// Define MUX_ARBITRO_RR_EN for round-robin arbitration; otherwise lowest index wins.
module mux_arbitro_nx1
    import mux_arbitro_nx1_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int N     = DEFAULT_N
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N-1:0]            valid_in,
    input  logic [N*WIDTH-1:0]      data_in,
    output logic [N-1:0]            ack_out,
    input  logic                    ready_in,
    output logic                    valid_out,
    output logic [WIDTH-1:0]        data_out,
    output logic [idx_width(N)-1:0] chan_out
);

    localparam int IW = idx_width(N);

    logic [IW-1:0] ptr;
    logic [N-1:0]  grant;
    logic [IW-1:0] grant_idx;
    logic          load;

    arbitro_rr #(
        .N  (N),
        .IW (IW)
    ) u_arbitro (
        .req   (valid_in),
        .ptr   (ptr),
        .grant (grant),
        .idx   (grant_idx)
    );

    // A word is taken only when the output slot is free or draining this cycle.
    assign load    = (!valid_out || ready_in) && (|valid_in) && !reset;
    assign ack_out = load ? grant : '0;

`ifdef MUX_ARBITRO_RR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
        end
    end
`else
    assign ptr = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            chan_out  <= '0;
        end else if (load) begin
            valid_out <= 1'b1;
            data_out  <= data_in[grant_idx*WIDTH +: WIDTH];
            chan_out  <= grant_idx;
        end else if (valid_out && ready_in) begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_arbitro_nx1.sv
// Self-checking bench for mux_arbitro_nx1 (N=4, WIDTH=2): directed scenarios with
// literal expectations, then randomized traffic checked against a behavioural model.
module tb_mux_arbitro_nx1;

    localparam int N = 4;
    localparam int W = 2;

    logic           clk;
    logic           reset;
    logic [N-1:0]   valid_in;
    logic [N*W-1:0] data_in;
    logic [N-1:0]   ack_out;
    logic           ready_in;
    logic           valid_out;
    logic [W-1:0]   data_out;
    logic [1:0]     chan_out;

    int tests;
    int fails;
    bit checking;

    // Behavioural model state
    bit m_valid;
    int m_data;
    int m_chan;
    int m_ptr;

    mux_arbitro_nx1 #(.WIDTH(W), .N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ack_out   (ack_out),
        .ready_in  (ready_in),
        .valid_out (valid_out),
        .data_out  (data_out),
        .chan_out  (chan_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // First requesting channel scanning start, start+1, ... modulo N; -1 if none.
    function automatic int pick(input logic [N-1:0] req, input int start);
        for (int k = 0; k < N; k++) begin
            if (req[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    function automatic int search_start();
`ifdef MUX_ARBITRO_RR_EN
        return m_ptr;
`else
        return 0;
`endif
    endfunction

    function automatic bit model_load();
        return (!m_valid || ready_in) && (valid_in != 0) && !reset;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model advances on every rising edge from the inputs the DUT sees.
    always @(posedge clk) begin
        int g;
        g = pick(valid_in, search_start());
        if (reset) begin
            m_valid <= 1'b0;
            m_data  <= 0;
            m_chan  <= 0;
            m_ptr   <= 0;
        end else if (model_load()) begin
            m_valid <= 1'b1;
            m_data  <= int'(data_in[g*W +: W]);
            m_chan  <= g;
            m_ptr   <= (g + 1) % N;
        end else if (m_valid && ready_in) begin
            m_valid <= 1'b0;
        end
    end

    // Compare process: mid-cycle, all outputs against the model.
    always @(negedge clk) begin
        int g;
        logic [N-1:0] exp_ack;
        if (checking) begin
            g = pick(valid_in, search_start());
            exp_ack = model_load() ? N'(1 << g) : '0;
            checkOutput("model_ack",   32'(ack_out),   32'(exp_ack));
            checkOutput("model_valid", 32'(valid_out), 32'(m_valid));
            checkOutput("model_data",  32'(data_out),  32'(m_data));
            checkOutput("model_chan",  32'(chan_out),  32'(m_chan));
        end
    end

    task automatic applyStimulus(input logic rst, input logic [N-1:0] v,
                                 input logic [N*W-1:0] d, input logic r);
        reset    = rst;
        valid_in = v;
        data_in  = d;
        ready_in = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int exp_seq[5];
        tests    = 0;
        fails    = 0;
        checking = 0;
        m_valid  = 0;
        m_data   = 0;
        m_chan   = 0;
        m_ptr    = 0;

        // Reset held for two cycles with every channel requesting
        applyStimulus(1'b1, 4'b1111, 8'b11_10_01_00, 1'b1);
        #1;
        checkOutput("reset_ack", 32'(ack_out), 32'h0);
        tick();
        checking = 1;
        tick();
        checkOutput("reset_valid", 32'(valid_out), 32'h0);
        checkOutput("reset_data",  32'(data_out),  32'h0);
        checkOutput("reset_chan",  32'(chan_out),  32'h0);

        // Single transfer from channel 2
        applyStimulus(1'b0, 4'b0100, 8'b00_11_00_00, 1'b1);
        #1;
        checkOutput("single_ack", 32'(ack_out), 32'b0100);
        tick();
        checkOutput("single_data",  32'(data_out),  32'b11);
        checkOutput("single_chan",  32'(chan_out),  32'd2);
        checkOutput("single_valid", 32'(valid_out), 32'd1);

        // Drain: valid drops, data held
        applyStimulus(1'b0, 4'b0000, 8'b00_00_00_00, 1'b1);
        tick();
        checkOutput("drain_valid", 32'(valid_out), 32'd0);
        checkOutput("drain_data",  32'(data_out),  32'b11);

        // Reset then all channels requesting, data equals channel number
        applyStimulus(1'b1, 4'b0000, 8'b11_10_01_00, 1'b1);
        tick();
`ifdef MUX_ARBITRO_RR_EN
        exp_seq = '{0, 1, 2, 3, 0};
`else
        exp_seq = '{0, 0, 0, 0, 0};
`endif
        applyStimulus(1'b0, 4'b1111, 8'b11_10_01_00, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("seq_chan%0d", i), 32'(chan_out), 32'(exp_seq[i]));
            checkOutput($sformatf("seq_data%0d", i), 32'(data_out), 32'(exp_seq[i]));
        end

        // Backpressure for three cycles with channel 1 requesting
        applyStimulus(1'b0, 4'b0010, 8'b11_10_01_00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("bp_ack", 32'(ack_out), 32'h0);
            tick();
            checkOutput("bp_chan",  32'(chan_out),  32'(exp_seq[4]));
            checkOutput("bp_valid", 32'(valid_out), 32'd1);
        end
        applyStimulus(1'b0, 4'b0010, 8'b11_10_01_00, 1'b1);
        #1;
        checkOutput("bp_release_ack", 32'(ack_out), 32'b0010);
        tick();
        checkOutput("bp_new_chan", 32'(chan_out), 32'd1);
        checkOutput("bp_new_data", 32'(data_out), 32'b01);

        // Reset while a word is held: word discarded, next grant from channel 0
        applyStimulus(1'b0, 4'b0010, 8'b11_10_01_00, 1'b0);
        tick();
        applyStimulus(1'b1, 4'b1111, 8'b11_10_01_00, 1'b0);
        #1;
        checkOutput("midreset_ack", 32'(ack_out), 32'h0);
        tick();
        checkOutput("midreset_valid", 32'(valid_out), 32'd0);
        checkOutput("midreset_data",  32'(data_out),  32'd0);
        applyStimulus(1'b0, 4'b1111, 8'b11_10_01_00, 1'b1);
        #1;
        checkOutput("post_reset_ack", 32'(ack_out), 32'b0001);
        tick();
        checkOutput("post_reset_chan", 32'(chan_out), 32'd0);

        // Randomized traffic, checked by the compare process
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 29) == 0),
                          N'($urandom),
                          (N*W)'($urandom),
                          ($urandom_range(0, 3) != 0));
            tick();
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
